// File: rtl/filter_pkg.sv
// Shared defaults and helpers for the FIR sample store.
package filter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 1024;
    localparam int NCH_DEF    = 2;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/filter_storage_ram.sv
// Simple dual-port synchronous RAM. A read and a write to the same word in one cycle return the old word.
module filter_storage_ram #(
    parameter int WIDTH = 32,
    parameter int WORDS = 2048,
    parameter int ABITS = 11
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [ABITS-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    // Non-blocking update of mem gives read-first ordering on address collision.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/filter_delay_line.sv
// Multi-channel circular sample store. Reads address by tap offset from the newest sample.
// Taps beyond the channel fill level read as zero.
module filter_delay_line
    import filter_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int NCH    = NCH_DEF,
    localparam int AW     = clog2(DEPTH),
    localparam int CHW    = (NCH > 1) ? clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              wr_en,
    input  logic [CHW-1:0]    wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [CHW-1:0]    rd_ch,
    input  logic [AW-1:0]     rd_tap,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clr,
    input  logic [CHW-1:0]    clr_ch,
    output logic [NCH-1:0]    full
);

    localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);

    logic [NCH-1:0][AW-1:0] head, head_nxt;
    logic [NCH-1:0][AW:0]   cnt, cnt_nxt;
    logic [NCH-1:0]         full_nxt;

    logic [AW-1:0]     rd_head, wr_head, rd_ptr;
    logic [AW:0]       rd_cnt;
    logic              wr_hit, wr_go, rd_mask, rd_zero;
    logic [DATA_W-1:0] ram_q;

    // Channel select; an index >= NCH matches nothing, so it reads as empty and never writes.
    always_comb begin
        rd_head = '0;
        rd_cnt  = '0;
        wr_head = '0;
        wr_hit  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (rd_ch == CHW'(c)) begin
                rd_head = head[c];
                rd_cnt  = cnt[c];
            end
            if (wr_ch == CHW'(c)) begin
                wr_head = head[c];
                wr_hit  = 1'b1;
            end
        end
    end

    assign wr_go   = wr_en && wr_hit && !(clr && clr_ch == wr_ch);
    assign rd_ptr  = rd_head - AW'(1) - rd_tap;
    assign rd_mask = {1'b0, rd_tap} >= rd_cnt;

    always_comb begin
        head_nxt = head;
        cnt_nxt  = cnt;
        full_nxt = '0;
        for (int c = 0; c < NCH; c++) begin
            if (clr && clr_ch == CHW'(c)) begin
                head_nxt[c] = '0;
                cnt_nxt[c]  = '0;
            end else if (wr_go && wr_ch == CHW'(c)) begin
                head_nxt[c] = head[c] + AW'(1);
                if (cnt[c] != CNT_MAX) cnt_nxt[c] = cnt[c] + (AW + 1)'(1);
            end
            full_nxt[c] = (cnt_nxt[c] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            head <= '0;
            cnt  <= '0;
            full <= '0;
        end else begin
            head <= head_nxt;
            cnt  <= cnt_nxt;
            full <= full_nxt;
        end
    end

    // rd_zero starts set so rd_data is zero out of reset without resetting the RAM register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_valid <= 1'b0;
            rd_zero  <= 1'b1;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_zero <= rd_mask;
        end
    end

    assign rd_data = rd_zero ? '0 : ram_q;

    filter_storage_ram #(
        .WIDTH (DATA_W),
        .WORDS (NCH * DEPTH),
        .ABITS (CHW + AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_go),
        .waddr ({wr_ch, wr_head}),
        .wdata (wr_data),
        .re    (rd_en && !rd_mask),
        .raddr ({rd_ch, rd_ptr}),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_filter_delay_line.sv
// Randomised check of filter_delay_line against a per-channel queue model.
module tb_filter_delay_line;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int NCH    = 3;
    localparam int AW     = 3;
    localparam int CHW    = 2;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              wr_en = 1'b0, rd_en = 1'b0, clr = 1'b0;
    logic [CHW-1:0]    wr_ch = '0, rd_ch = '0, clr_ch = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [AW-1:0]     rd_tap = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [NCH-1:0]    full;

    int n_chk = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] mq [NCH][$];
    logic [DATA_W-1:0] last_data = '0;

    filter_delay_line #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NCH(NCH)) dut (
        .clk(clk), .rstb(rstb),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_tap(rd_tap),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .clr(clr), .clr_ch(clr_ch), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input int ch, input int tap);
        if (ch >= NCH) return '0;
        if (tap >= mq[ch].size()) return '0;
        return mq[ch][mq[ch].size() - 1 - tap];
    endfunction

    function automatic logic [NCH-1:0] model_full();
        logic [NCH-1:0] f;
        for (int c = 0; c < NCH; c++) f[c] = (mq[c].size() == DEPTH);
        return f;
    endfunction

    // Drives one cycle of inputs, advances the model, checks outputs just after the edge.
    task automatic step(input bit we, input int wch, input logic [DATA_W-1:0] wd,
                        input bit re, input int rch, input int tap,
                        input bit cl, input int cch);
        wr_en = we; wr_ch = CHW'(wch); wr_data = wd;
        rd_en = re; rd_ch = CHW'(rch); rd_tap = AW'(tap);
        clr = cl; clr_ch = CHW'(cch);
        if (re) last_data = model_read(rch, tap);
        if (cl && cch < NCH) mq[cch].delete();
        if (we && wch < NCH && !(cl && cch == wch)) begin
            mq[wch].push_back(wd);
            if (mq[wch].size() > DEPTH) void'(mq[wch].pop_front());
        end
        @(posedge clk);
        #1;
        chk("rd_valid", 64'(rd_valid), 64'(re));
        chk("rd_data", 64'(rd_data), 64'(last_data));
        chk("full", 64'(full), 64'(model_full()));
    endtask

    task automatic push(input int ch, input logic [DATA_W-1:0] d);
        step(1, ch, d, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int ch, input int tap);
        step(0, 0, '0, 1, ch, tap, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;
        chk("reset_valid", 64'(rd_valid), 64'd0);
        chk("reset_data", 64'(rd_data), 64'd0);
        chk("reset_full", 64'(full), 64'd0);

        rd(0, 0);
        push(0, 32'h11); push(0, 32'h22); push(0, 32'h33);
        for (int t = 0; t < 4; t++) rd(0, t);

        for (int i = 0; i < 4; i++) begin
            push(0, 32'hA0 + i);
            push(1, 32'hB0 + i);
        end
        rd(1, 0);
        chk("ch1_tap0", 64'(rd_data), 64'hB3);
        rd(0, 0);

        step(0, 0, '0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) push(0, DATA_W'(i));
        chk("full_after_10", 64'(full[0]), 64'd1);
        for (int t = 0; t < DEPTH; t++) rd(0, t);

        // Write and read the oldest tap together on a full channel.
        step(1, 0, 32'h55, 1, 0, 7, 0, 0);
        chk("collide_old", 64'(rd_data), 64'd3);
        rd(0, 0);
        chk("collide_new", 64'(rd_data), 64'h55);

        step(1, 0, 32'h77, 1, 0, 0, 1, 0);
        rd(0, 0);
        chk("clr_drop", 64'(rd_data), 64'd0);

        step(1, 3, 32'hDEAD, 1, 3, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom,
                 $urandom_range(0, 1) != 0, $urandom_range(0, 3), $urandom_range(0, DEPTH - 1),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of a read burst.
        wr_en = 1'b1; rd_en = 1'b1; rd_ch = '0; rd_tap = '0;
        @(posedge clk);
        #3 rstb = 1'b0;
        #1;
        chk("arst_valid", 64'(rd_valid), 64'd0);
        chk("arst_data", 64'(rd_data), 64'd0);
        chk("arst_full", 64'(full), 64'd0);
        wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk);
        #1 rstb = 1'b1;
        for (int c = 0; c < NCH; c++) mq[c].delete();
        last_data = '0;

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 1) != 0, $urandom_range(0, 3), $urandom,
                 $urandom_range(0, 1) != 0, $urandom_range(0, 3), $urandom_range(0, DEPTH - 1),
                 $urandom_range(0, 63) == 0, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
